butterfly_s2p: RTL and testbench



---
 rtl/butterfly_pkg.sv | 14 +
 rtl/butterfly_s2p_if.sv | 30 +++
 rtl/butterfly_s2p_bank.sv | 55 +++++
 rtl/butterfly_s2p.sv | 92 +++++++++
 tb/tb_butterfly_s2p.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/butterfly_pkg.sv
// Shared definitions for the butterfly serial/parallel blocks:
// the slot index width helper and the ping-pong bank state encoding.
package butterfly_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  function automatic int idx_width(input int num_input);
    return $clog2(num_input);
  endfunction

endpackage

// File: rtl/butterfly_s2p_if.sv
// Handshake bundle between the butterfly serializer output and the S2P collector.
// The master side feeds words and consumes vectors; the slave side is the collector.
interface butterfly_s2p_if #(
  parameter int data_width = 16,
  parameter int num_input  = 8
);
  import butterfly_pkg::*;

  localparam int IW = idx_width(num_input);

  logic                            clear;
  logic [data_width-1:0]           up_dat;
  logic                            up_vld;
  logic                            up_rdy;
  logic [num_input*data_width-1:0] dn_dat;
  logic                            dn_vld;
  logic                            dn_rdy;
  logic [IW-1:0]                   grp_cnt;

  modport master (
    output clear, up_dat, up_vld, dn_rdy,
    input  up_rdy, dn_dat, dn_vld, grp_cnt
  );

  modport slave (
    input  clear, up_dat, up_vld, dn_rdy,
    output up_rdy, dn_dat, dn_vld, grp_cnt
  );

endinterface

// File: rtl/butterfly_s2p_bank.sv
// One ping-pong bank: a slot-addressed word array plus an EMPTY/FULL flag.
// clear only resets the flag; the stored words are left as they are.
module butterfly_s2p_bank
  import butterfly_pkg::*;
#(
  parameter int  data_width = 16,
  parameter int  num_input  = 8,
  localparam int IW         = idx_width(num_input)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            wr_en,
  input  logic [IW-1:0]                   wr_slot,
  input  logic [data_width-1:0]           wr_dat,
  input  logic                            set_full,
  input  logic                            release_full,
  output logic                            full,
  output logic [num_input*data_width-1:0] data
);

  logic [data_width-1:0] mem [num_input];
  bank_state_t           state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < num_input; s++) begin
        mem[s] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_slot] <= wr_dat;
    end
  end

  // set and release never target the same bank in one cycle: a bank is
  // only completed while EMPTY and only released while FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else if (clear) begin
      state <= EMPTY;
    end else if (set_full) begin
      state <= FULL;
    end else if (release_full) begin
      state <= EMPTY;
    end
  end

  assign full = (state == FULL);

  for (genvar s = 0; s < num_input; s++) begin : g_flat
    assign data[s*data_width +: data_width] = mem[s];
  end

endmodule

// File: rtl/butterfly_s2p.sv
// Serial-to-parallel collector with two ping-pong banks behind the butterfly serializer.
// Define BUTTERFLY_S2P_PERMUTE_EN to rotate the write slot by grp_cnt each group.
module butterfly_s2p
  import butterfly_pkg::*;
#(
  parameter int data_width = 16,
  parameter int num_input  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  butterfly_s2p_if.slave  bus
);

  localparam int             IW        = idx_width(num_input);
  localparam logic [IW-1:0]  LAST_SLOT = IW'(num_input - 1);

  logic [IW-1:0]                   wr_cnt;
  logic [IW-1:0]                   grp_cnt;
  logic [IW-1:0]                   slot;
  logic                            fill_ptr;
  logic                            drain_ptr;
  logic [1:0]                      bank_full;
  logic [num_input*data_width-1:0] bank_data [2];
  logic                            up_rdy;
  logic                            dn_vld;
  logic                            accept;
  logic                            last_word;
  logic                            release_vec;

  assign up_rdy      = !bus.clear && !bank_full[fill_ptr];
  assign accept      = bus.up_vld && up_rdy;
  assign last_word   = accept && (wr_cnt == LAST_SLOT);
  assign dn_vld      = bank_full[drain_ptr];
  assign release_vec = dn_vld && bus.dn_rdy;

  // Rotation undoes the per-group rotated readout of the upstream serializer
`ifdef BUTTERFLY_S2P_PERMUTE_EN
  assign slot = wr_cnt + grp_cnt;
`else
  assign slot = wr_cnt;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    butterfly_s2p_bank #(
      .data_width (data_width),
      .num_input  (num_input)
    ) u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (bus.clear),
      .wr_en        (accept && (fill_ptr == 1'(b))),
      .wr_slot      (slot),
      .wr_dat       (bus.up_dat),
      .set_full     (last_word && (fill_ptr == 1'(b))),
      .release_full (release_vec && (drain_ptr == 1'(b))),
      .full         (bank_full[b]),
      .data         (bank_data[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      grp_cnt   <= '0;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else if (bus.clear) begin
      wr_cnt    <= '0;
      grp_cnt   <= '0;
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + IW'(1);
      end
      if (last_word) begin
        fill_ptr <= !fill_ptr;
        grp_cnt  <= grp_cnt + IW'(1);
      end
      if (release_vec) begin
        drain_ptr <= !drain_ptr;
      end
    end
  end

  // The drain pointer and bank contents are all registers, so the output port stays glitch-free
  assign bus.up_rdy  = up_rdy;
  assign bus.dn_vld  = dn_vld;
  assign bus.dn_dat  = bank_data[drain_ptr];
  assign bus.grp_cnt = grp_cnt;

endmodule

// File: tb/tb_butterfly_s2p.sv
// Self-checking bench for butterfly_s2p: a fixed vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_butterfly_s2p;

  localparam int DW = 16;
  localparam int NI = 8;
  localparam int IW = 3;

  typedef logic [NI*DW-1:0] vec_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          vld;
    logic          rdy;
    logic          exp_rdy;
    logic          exp_vld;
    logic [IW-1:0] exp_grp;
    vec_t          exp_dat;
  } row_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  butterfly_s2p_if #(.data_width(DW), .num_input(NI)) bus ();

  butterfly_s2p #(.data_width(DW), .num_input(NI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: words gathered into a partial group, completed vectors queued
  logic [DW-1:0] m_part[$];
  vec_t          m_pend[$];
  int            m_grp;
  bit            m_acc;

  function automatic int slotOf(input int i, input int grp);
`ifdef BUTTERFLY_S2P_PERMUTE_EN
    return (i + grp) % NI;
`else
    return i + 0 * grp;
`endif
  endfunction

  task automatic modelReset();
    m_part.delete();
    m_pend.delete();
    m_grp = 0;
    m_acc = 0;
  endtask

  task automatic modelEdge();
    bit   rel;
    vec_t v;
    m_acc = 0;
    if (bus.clear) begin
      modelReset();
    end else begin
      rel   = (m_pend.size() > 0) && bus.dn_rdy;
      m_acc = bus.up_vld && (m_pend.size() < 2);
      if (rel) void'(m_pend.pop_front());
      if (m_acc) begin
        m_part.push_back(bus.up_dat);
        if (m_part.size() == NI) begin
          v = '0;
          for (int i = 0; i < NI; i++) v[slotOf(i, m_grp)*DW +: DW] = m_part[i];
          m_pend.push_back(v);
          m_grp = (m_grp + 1) % NI;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic checkValue(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic exp_rdy, input logic exp_vld,
                             input vec_t exp_dat, input logic [IW-1:0] exp_grp);
    checkValue({name, ".up_rdy"},  vec_t'(bus.up_rdy),  vec_t'(exp_rdy));
    checkValue({name, ".dn_vld"},  vec_t'(bus.dn_vld),  vec_t'(exp_vld));
    checkValue({name, ".grp_cnt"}, vec_t'(bus.grp_cnt), vec_t'(exp_grp));
    if (exp_vld) checkValue({name, ".dn_dat"}, bus.dn_dat, exp_dat);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] dat, input logic vld,
                               input logic rdy, input logic clr);
    bus.up_dat = dat;
    bus.up_vld = vld;
    bus.dn_rdy = rdy;
    bus.clear  = clr;
  endtask

  task automatic runCycle(input bit chk);
    #1;
    if (chk) checkOutput("model", !bus.clear && (m_pend.size() < 2), m_pend.size() > 0,
                         (m_pend.size() > 0) ? m_pend[0] : '0, IW'(m_grp));
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic feedWords(input int count, input logic [DW-1:0] base, input logic rdy,
                           input int budget, output int accepted);
    accepted = 0;
    for (int c = 0; c < budget && accepted < count; c++) begin
      applyStimulus(base + DW'(accepted), 1'b1, rdy, 1'b0);
      runCycle(1'b1);
      if (m_acc) accepted++;
    end
    applyStimulus('0, 1'b0, rdy, 1'b0);
  endtask

  row_t tbl[18];
  vec_t vec1, vec2;
  int   acc;

  initial begin
    // Expected vectors for the first two groups after reset
    vec1 = '0;
    vec2 = '0;
    for (int s = 0; s < NI; s++) begin
      vec1[s*DW +: DW] = DW'(16'h0001 + s);
`ifdef BUTTERFLY_S2P_PERMUTE_EN
      vec2[((s + 1) % NI)*DW +: DW] = DW'(16'h0011 + s);
`else
      vec2[s*DW +: DW] = DW'(16'h0011 + s);
`endif
    end
    for (int r = 0; r < 18; r++) begin
      tbl[r].dat     = (r < 8) ? DW'(16'h0001 + r) : DW'(16'h0011 + r - 8);
      tbl[r].vld     = (r < 16);
      tbl[r].rdy     = 1'b1;
      tbl[r].exp_rdy = 1'b1;
      tbl[r].exp_vld = (r == 8) || (r == 16);
      tbl[r].exp_grp = (r < 8) ? 3'd0 : (r < 16) ? 3'd1 : 3'd2;
      tbl[r].exp_dat = (r == 16) ? vec2 : vec1;
    end

    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in_reset", 1'b1, 1'b0, '0, '0);
    checkValue("in_reset.dn_dat", bus.dn_dat, '0);
    rst_n = 1'b1;
    #1;
    checkOutput("after_reset", 1'b1, 1'b0, '0, '0);
    checkValue("after_reset.dn_dat", bus.dn_dat, '0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 18; r++) begin
      applyStimulus(tbl[r].dat, tbl[r].vld, tbl[r].rdy, 1'b0);
      #1;
      checkOutput($sformatf("tbl%0d", r), tbl[r].exp_rdy, tbl[r].exp_vld,
                  tbl[r].exp_dat, tbl[r].exp_grp);
      runCycle(1'b0);
    end

    // Both banks fill with the consumer stalled; the 17th word waits for a release
    feedWords(17, 16'h0100, 1'b0, 20, acc);
    checkValue("stall_accepts", vec_t'(acc), vec_t'(16));
    checkValue("stall_up_rdy", vec_t'(bus.up_rdy), '0);
    feedWords(1, 16'h0110, 1'b1, 10, acc);
    checkValue("stall_resume", vec_t'(acc), vec_t'(1));
    for (int c = 0; c < 4; c++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      runCycle(1'b1);
    end

    // Flush, then nine groups to walk grp_cnt through its wrap
    applyStimulus(16'hbeef, 1'b1, 1'b1, 1'b1);
    runCycle(1'b1);
    feedWords(64, 16'h0200, 1'b1, 80, acc);
    checkValue("grp_accepts", vec_t'(acc), vec_t'(64));
    checkValue("grp_wrap", vec_t'(bus.grp_cnt), '0);
    checkValue("grp_wrap_vld", vec_t'(bus.dn_vld), vec_t'(1));
    feedWords(8, 16'h0300, 1'b1, 12, acc);
    checkValue("grp_after_wrap", vec_t'(bus.grp_cnt), vec_t'(1));
    for (int c = 0; c < 2; c++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      runCycle(1'b1);
    end

    // clear part way through a group
    feedWords(5, 16'h0400, 1'b1, 8, acc);
    applyStimulus(16'hdead, 1'b1, 1'b1, 1'b1);
    #1;
    checkValue("clear_up_rdy", vec_t'(bus.up_rdy), '0);
    runCycle(1'b1);
    checkValue("clear_grp", vec_t'(bus.grp_cnt), '0);
    checkValue("clear_dn_vld", vec_t'(bus.dn_vld), '0);
    feedWords(8, 16'h0500, 1'b1, 12, acc);
    checkValue("clear_fresh_grp", vec_t'(bus.grp_cnt), vec_t'(1));
    checkValue("clear_fresh_vld", vec_t'(bus.dn_vld), vec_t'(1));
    for (int c = 0; c < 2; c++) begin
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
      runCycle(1'b1);
    end

    // Asynchronous reset with one bank FULL and a partial group in flight
    feedWords(12, 16'h0600, 1'b0, 16, acc);
    checkValue("prereset_vld", vec_t'(bus.dn_vld), vec_t'(1));
    rst_n = 1'b0;
    #1;
    checkValue("async_rst.dn_vld", vec_t'(bus.dn_vld), '0);
    checkValue("async_rst.dn_dat", bus.dn_dat, '0);
    checkValue("async_rst.grp_cnt", vec_t'(bus.grp_cnt), '0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    feedWords(8, 16'h0001, 1'b1, 12, acc);
    checkValue("rerun_vld", vec_t'(bus.dn_vld), vec_t'(1));
    checkValue("rerun_dat", bus.dn_dat, vec1);
    checkValue("rerun_grp", vec_t'(bus.grp_cnt), vec_t'(1));

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      applyStimulus(DW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 63) == 0);
      runCycle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
